counter_modulo_prog: RTL
========================

Name: counter_modulo_prog

Overview:
Parametrised, runtime-programmable modulo-N counter. It is the successor to the fixed-modulo up-counter, adding up/down direction, a programmable terminal value, synchronous load, one-shot (halt-at-terminal) mode and a combinational terminal-count output for cascading. It is used as a timebase and prescaler, and as a digit or step counter in the lab designs.

Parameters:
MAX_MODULO, 16, largest modulo supported; sets the counter range 0..MAX_MODULO-1.
WIDTH, $clog2(MAX_MODULO), width of the count, load and terminal values.
DEFAULT_MODULO, 7, modulo in effect after reset; must satisfy 1 <= DEFAULT_MODULO <= MAX_MODULO.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
ce  input  1  count enable; one step per cycle while high.
up  input  1  direction: 1 counts up, 0 counts down.
one_shot  input  1  1 halts at the terminal event; 0 wraps.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load.
mod_wr  input  1  writes a new terminal value.
term_val  input  WIDTH  new terminal value, equal to modulo-1.
out  output  WIDTH  current count (registered).
tc  output  1  terminal count (combinational): this cycle's step wraps or halts.
done  output  1  registered; high while halted in one-shot mode.

Behaviour:
- Interface: single clock clk. rst is synchronous and active-high.
- Internal state:
  - val (count register).
  - term (terminal register).
  - FSM with states RUN and HALT.
- Reset: val=0, term=DEFAULT_MODULO-1, state=RUN, done=0, out=0. rst has priority over every other input.
- Terminal condition: at_term = up ? (val==term) : (val==0).
- tc = ce & at_term & (state==RUN) & ~load. tc is never high in HALT.
- Priority after rst, evaluated each cycle: load, then count step. mod_wr is processed in parallel with either.
- mod_wr:
  - term <= term_val, effective the next cycle.
  - If the same cycle has no load and no count step, and val > term_val, then val <= 0.
  - If the same cycle has a count step, the step is evaluated against the new term_val: a step crossing the new term wraps to 0 (up) or to term_val (down).
- load:
  - val <= min(load_val, T), where T is term_val if mod_wr is also high this cycle, else term.
  - state <= RUN and done <= 0.
  - load acts regardless of ce, and ce is ignored in that cycle.
- Count step (state RUN, ce=1, no load):
  - Up: val <= at_term ? 0 : val+1.
  - Down: val <= at_term ? term : val-1.
  - If at_term and one_shot=1: val holds (term when up, 0 when down), state <= HALT, done <= 1.
- HALT:
  - ce and up are ignored, and val holds.
  - Exit only via load or rst. Deasserting one_shot does not exit HALT.
  - mod_wr in HALT updates term; val is clamped to 0 if val > new term, and the block stays in HALT.
- ce=0 in RUN: val holds; tc=0.
- Modulo 1 (term=0): val stays 0. With ce=1 in RUN, tc is high every cycle.
- Changing direction mid-count takes effect on the next step from the current val. There is no phase reset.
- Latency: a step or load is visible on out one cycle after the qualifying edge. tc is valid in the same cycle as its inputs.
- Arithmetic: WIDTH-bit unsigned. val never exceeds term.

Test Plan:
1. Default up count: rst, then up=1, ce=1 for 15 cycles -> out 0,1..6,0..6,0. tc high exactly in the cycles where out=6. done=0 throughout.
2. Down wrap: after rst, up=0, ce=1 -> out 0,6,5,4,3,2,1,0,6. tc high when out=0. Toggle ce=0 for 3 cycles mid-count -> out holds and tc=0.
3. Runtime modulo:
   - At out=5, pulse mod_wr with term_val=3 (no ce that cycle) -> out=0, then counts 0,1,2,3,0.
   - mod_wr term_val=9 while out=2 -> counts continue 3..9,0.
4. Load and clamp:
   - term=6, load=1, load_val=12 -> out=6.
   - load=1 with load_val=2 and ce=1 in the same cycle -> out=2 (load wins, no step).
   - load + mod_wr(term_val=1) with load_val=5 -> out=1.
5. One-shot:
   - one_shot=1, up=1, from out=4 -> 5,6. tc pulses once at out=6, then done=1; out stays 6 for 5 further ce cycles with tc=0.
   - Clear one_shot -> still halted.
   - load load_val=2 -> done=0, out 2,3,...
6. Reset mid-operation: term=3, halted with done=1, assert rst for 1 cycle -> out=0, done=0. Counting then wraps at 6 (term restored to DEFAULT_MODULO-1).

Source files
------------

// File: rtl/counter_modulo_prog.sv
// Runtime-programmable modulo-N up/down counter with synchronous load,
// one-shot halt at the terminal event and a combinational terminal-count output.
module counter_modulo_prog #(
    parameter int MAX_MODULO     = 16,
    parameter int WIDTH          = $clog2(MAX_MODULO),
    parameter int DEFAULT_MODULO = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(DEFAULT_MODULO - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] val, val_nxt;
    logic [WIDTH-1:0] term, term_nxt;
    logic [WIDTH-1:0] eff_term;
    logic [WIDTH-1:0] val_dec;
    logic             done_nxt;
    logic             at_term;
    logic             step;
    logic             step_wrap;

    assign out = val;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        at_term   = up ? (val == term) : (val == '0);
        tc        = ce & at_term & (state == RUN) & ~load;
        eff_term  = mod_wr ? term_val : term;
        step      = (state == RUN) & ce & ~load;
        // A step in the same cycle as mod_wr is judged against the new terminal.
        step_wrap = up ? (val >= eff_term) : (val == '0);
        val_dec   = val - 1'b1;

        val_nxt   = val;
        term_nxt  = eff_term;
        state_nxt = state;
        done_nxt  = done;

        if (load) begin
            val_nxt   = (load_val > eff_term) ? eff_term : load_val;
            state_nxt = RUN;
            done_nxt  = 1'b0;
        end else if (step) begin
            if (step_wrap && one_shot) begin
                val_nxt   = up ? eff_term : '0;
                state_nxt = HALT;
                done_nxt  = 1'b1;
            end else if (step_wrap) begin
                val_nxt = up ? '0 : eff_term;
            end else if (up) begin
                val_nxt = val + 1'b1;
            end else begin
                val_nxt = (val_dec > eff_term) ? eff_term : val_dec;
            end
        end else if (mod_wr && (val > term_val)) begin
            // Keeps val within range when the terminal shrinks below it.
            val_nxt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; rst is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            val   <= '0;
            term  <= TERM_RST;
            state <= RUN;
            done  <= 1'b0;
        end else begin
            val   <= val_nxt;
            term  <= term_nxt;
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

endmodule
